// File: rtl/argmax_pkg.sv
// Shared types and helpers for the streaming reduction blocks (argmax and friends).
package argmax_pkg;

  typedef enum logic {ACCUM, RESULT} state_t;

  // Index width that never collapses to zero bits.
  function automatic int idx_w(input int n);
    return (n > 2) ? $clog2(n) : 1;
  endfunction

  // a > b for w-bit operands zero-extended to 64 bits. Flipping the sign bit maps
  // two's-complement ordering onto unsigned ordering, so one comparator serves both.
  function automatic logic gt(input logic [63:0] a, input logic [63:0] b,
                              input int w, input bit sgn);
    logic [63:0] flip;
    flip = sgn ? (64'd1 << (w - 1)) : 64'd0;
    return (a ^ flip) > (b ^ flip);
  endfunction

endpackage

// File: rtl/argmax_update.sv
// Compare-select for one score beat: keep the running max or take the new score.
module argmax_update
  import argmax_pkg::*;
#(
  parameter int WIDTH  = 16,
  parameter int IW     = 2,
  parameter int SIGNED = 0
) (
  input  logic [WIDTH-1:0] cur_val,
  input  logic [IW-1:0]    cur_idx,
  input  logic [WIDTH-1:0] new_val,
  input  logic [IW-1:0]    new_idx,
  input  logic             first,
  output logic [WIDTH-1:0] next_val,
  output logic [IW-1:0]    next_idx
);

  logic take;

  // Strict compare keeps the lowest index on ties.
  assign take     = first || gt(64'(new_val), 64'(cur_val), WIDTH, SIGNED != 0);
  assign next_val = take ? new_val : cur_val;
  assign next_idx = take ? new_idx : cur_idx;

endmodule

// File: rtl/argmax_stream_ctrl.sv
// Frame-wise argmax over a valid/ready score stream; one result beat per N scores.
module argmax_stream_ctrl
  import argmax_pkg::*;
#(
  parameter int N      = 4,
  parameter int WIDTH  = 16,
  parameter int SIGNED = 0
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [WIDTH-1:0]     in_data,
  input  logic                 in_last,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [$clog2(N)-1:0] out_index,
  output logic [WIDTH-1:0]     out_value,
  output logic                 out_err
);

  localparam int IW = idx_w(N);
  localparam logic [IW-1:0] LAST_CNT = IW'(N - 1);

  state_t           state;
  logic [IW-1:0]    cnt;
  logic [WIDTH-1:0] max_val;
  logic [IW-1:0]    max_idx;
  logic             err;

  logic             accept;
  logic             first;
  logic             last_beat;
  logic             beat_err;
  logic [WIDTH-1:0] next_val;
  logic [IW-1:0]    next_idx;

  assign in_ready  = (state == ACCUM);
  assign out_valid = (state == RESULT);
  assign out_index = max_idx;
  assign out_value = max_val;
  assign out_err   = err;

  assign accept    = in_valid && in_ready;
  assign first     = (cnt == '0);
  assign last_beat = (cnt == LAST_CNT);
  // in_last is only checked against the counter; it never changes the frame length.
  assign beat_err  = last_beat ? !in_last : in_last;

  argmax_update #(
    .WIDTH  (WIDTH),
    .IW     (IW),
    .SIGNED (SIGNED)
  ) u_update (
    .cur_val  (max_val),
    .cur_idx  (max_idx),
    .new_val  (in_data),
    .new_idx  (cnt),
    .first    (first),
    .next_val (next_val),
    .next_idx (next_idx)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state   <= ACCUM;
      cnt     <= '0;
      max_val <= '0;
      max_idx <= '0;
      err     <= 1'b0;
    end else begin
      case (state)
        ACCUM: begin
          if (accept) begin
            max_val <= next_val;
            max_idx <= next_idx;
            err     <= beat_err || (err && !first);
            if (last_beat) begin
              cnt   <= '0;
              state <= RESULT;
            end else begin
              cnt <= cnt + 1'b1;
            end
          end
        end
        RESULT: begin
          if (out_ready) state <= ACCUM;
        end
        default: state <= ACCUM;
      endcase
    end
  end

endmodule

// File: tb/tb_argmax_stream_ctrl.sv
// Drives one stream into an unsigned and a signed instance and checks both against a frame-level model.
module tb_argmax_stream_ctrl;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic [15:0] in_data;
  logic        in_last;
  logic        out_ready;

  logic        in_ready0, out_valid0, out_err0;
  logic [1:0]  out_index0;
  logic [15:0] out_value0;
  logic        in_ready1, out_valid1, out_err1;
  logic [1:0]  out_index1;
  logic [15:0] out_value1;

  int passed = 0;
  int total  = 0;

  always #5 clk = ~clk;

  argmax_stream_ctrl #(.N(4), .WIDTH(16), .SIGNED(0)) dut0 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready0),
    .in_data(in_data), .in_last(in_last), .out_valid(out_valid0), .out_ready(out_ready),
    .out_index(out_index0), .out_value(out_value0), .out_err(out_err0)
  );

  argmax_stream_ctrl #(.N(4), .WIDTH(16), .SIGNED(1)) dut1 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready1),
    .in_data(in_data), .in_last(in_last), .out_valid(out_valid1), .out_ready(out_ready),
    .out_index(out_index1), .out_value(out_value1), .out_err(out_err1)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total = total + 1;
    assert (obs === exp) passed = passed + 1;
    else $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
  endtask

  // Reference: plain arithmetic argmax over the whole frame, first maximum wins.
  function automatic longint key(input logic [15:0] v, input bit sgn);
    return sgn ? longint'($signed(v)) : longint'(v);
  endfunction

  task automatic ref_frame(input logic [15:0] s [4], input logic [3:0] l, input bit sgn,
                           output int idx, output logic [15:0] val, output logic err);
    idx = 0;
    for (int i = 1; i < 4; i++)
      if (key(s[i], sgn) > key(s[idx], sgn)) idx = i;
    val = s[idx];
    err = (l[2:0] != 3'b000) || !l[3];
  endtask

  task automatic check_result(input string tag, input logic [15:0] s [4], input logic [3:0] l);
    int idx;
    logic [15:0] val;
    logic err;
    ref_frame(s, l, 1'b0, idx, val, err);
    chk($sformatf("%s u.valid", tag), out_valid0, 1);
    chk($sformatf("%s u.index", tag), out_index0, idx);
    chk($sformatf("%s u.value", tag), out_value0, val);
    chk($sformatf("%s u.err", tag), out_err0, err);
    ref_frame(s, l, 1'b1, idx, val, err);
    chk($sformatf("%s s.valid", tag), out_valid1, 1);
    chk($sformatf("%s s.index", tag), out_index1, idx);
    chk($sformatf("%s s.value", tag), out_value1, val);
    chk($sformatf("%s s.err", tag), out_err1, err);
    chk($sformatf("%s in_ready", tag), in_ready0, 0);
    $display("frame %s: data=%h %h %h %h last=%b -> u idx=%0d val=%h err=%b | s idx=%0d val=%h err=%b",
             tag, s[0], s[1], s[2], s[3], l, out_index0, out_value0, out_err0,
             out_index1, out_value1, out_err1);
  endtask

  // Called and returns at a negedge; the beat is accepted at the posedge in between.
  task automatic send_beat(input string tag, input logic [15:0] d, input logic l);
    int waited = 0;
    in_valid = 1'b1;
    in_data  = d;
    in_last  = l;
    while (!in_ready0 && waited < 50) begin
      @(negedge clk);
      waited++;
    end
    if (waited >= 50) chk($sformatf("%s ready_timeout", tag), in_ready0, 1);
    chk($sformatf("%s busy_valid", tag), out_valid0, 0);
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  task automatic run_frame(input string tag, input logic [15:0] s [4], input logic [3:0] l,
                           input bit gaps, input int bp, input bit hold,
                           input logic [15:0] held);
    out_ready = (bp == 0);
    for (int i = 0; i < 4; i++) begin
      send_beat(tag, s[i], l[i]);
      if (gaps && i < 3) repeat ($urandom_range(0, 2)) @(negedge clk);
    end
    check_result(tag, s, l);
    if (bp > 0) begin
      if (hold) begin
        in_valid = 1'b1;
        in_data  = held;
        in_last  = 1'b0;
      end
      for (int k = 0; k < bp; k++) begin
        @(negedge clk);
        check_result($sformatf("%s bp%0d", tag, k), s, l);
      end
      out_ready = 1'b1;
    end
    @(negedge clk);
    chk($sformatf("%s done.valid", tag), out_valid0, 0);
    chk($sformatf("%s done.ready", tag), in_ready0, 1);
  endtask

  initial begin
    logic [15:0] s [4];
    logic [3:0]  l;
    logic [15:0] nxt [4];

    rst_n = 1'b0; in_valid = 1'b0; in_data = '0; in_last = 1'b0; out_ready = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("reset u.valid", out_valid0, 0);
    chk("reset u.index", out_index0, 0);
    chk("reset u.value", out_value0, 0);
    chk("reset u.err", out_err0, 0);
    chk("reset s.valid", out_valid1, 0);
    rst_n = 1'b1;
    @(negedge clk);
    chk("reset in_ready", in_ready0, 1);

    s = '{16'd3, 16'd9, 16'd2, 16'd7};                  run_frame("basic", s, 4'b1000, 0, 0, 0, 16'd0);
    s = '{16'd5, 16'd8, 16'd8, 16'd1};                  run_frame("tie", s, 4'b1000, 0, 0, 0, 16'd0);
    s = '{16'hFFFE, 16'hFFF0, 16'h8000, 16'hFFFF};      run_frame("negs", s, 4'b1000, 0, 0, 0, 16'd0);
    s = '{16'h0001, 16'hFFFF, 16'h0000, 16'h0000};      run_frame("sign", s, 4'b1000, 0, 0, 0, 16'd0);

    // Next frame's first beat is presented during backpressure and must survive it.
    s   = '{16'd10, 16'd20, 16'd30, 16'd5};
    nxt = '{16'd40, 16'd1, 16'd2, 16'd3};
    run_frame("bp", s, 4'b1000, 0, 5, 1, nxt[0]);
    run_frame("after_bp", nxt, 4'b1000, 0, 0, 0, 16'd0);

    s = '{16'd4, 16'd6, 16'd6, 16'd2};                  run_frame("early_last", s, 4'b0010, 1, 0, 0, 16'd0);
    s = '{16'd4, 16'd6, 16'd6, 16'd2};                  run_frame("clean", s, 4'b1000, 1, 0, 0, 16'd0);
    s = '{16'd1, 16'd0, 16'd0, 16'd9};                  run_frame("no_last", s, 4'b0000, 0, 0, 0, 16'd0);

    // Partial frame thrown away by reset.
    send_beat("midrst", 16'd100, 1'b0);
    send_beat("midrst", 16'd200, 1'b0);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    chk("midrst u.valid", out_valid0, 0);
    chk("midrst u.value", out_value0, 0);
    chk("midrst u.index", out_index0, 0);
    chk("midrst in_ready", in_ready0, 1);
    @(negedge clk);
    chk("midrst idle.valid", out_valid0, 0);
    s = '{16'd1, 16'd2, 16'd3, 16'd4};                  run_frame("post_rst", s, 4'b1000, 0, 0, 0, 16'd0);

    for (int f = 0; f < 30; f++) begin
      for (int i = 0; i < 4; i++)
        s[i] = $urandom_range(0, 1) ? 16'($urandom) : 16'($urandom_range(0, 3));
      l = ($urandom_range(0, 4) != 0) ? 4'b1000 : 4'($urandom);
      run_frame($sformatf("rnd%0d", f), s, l, 1'($urandom_range(0, 1)),
                $urandom_range(0, 3), 0, 16'd0);
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, %0d/%0d checks so far", passed, total);
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/argmax_stream_ctrl.md
# argmax_stream_ctrl

Sequential argmax controller for the classifier tail of the CNN accelerator. It accepts one score per cycle from the final dense layer over a valid/ready stream and tracks a running maximum and its index across a frame of N scores. At the end of each frame it emits one result beat: class index, winning score and a framing-error flag. It replaces a wide N×WIDTH combinational compare with a single comparator plus a small FSM.

## Interface
Parameters:
- N, 4, scores per frame (classes); N ≥ 2
- WIDTH, 16, score bitwidth
- SIGNED, 0, 0 = unsigned compare, 1 = two's-complement compare

Ports:
- clk  in  1  rising-edge clock
- rst_n  in  1  reset; synchronous, active-low
- in_valid  in  1  score beat valid
- in_ready  out  1  controller can accept a beat
- in_data  in  WIDTH  score
- in_last  in  1  producer marks final score of frame
- out_valid  out  1  result valid
- out_ready  in  1  consumer accepts result
- out_index  out  $clog2(N)  argmax class index
- out_value  out  WIDTH  maximum score
- out_err  out  1  frame length mismatch detected for this result

## Operation
- Beat accepted when in_valid && in_ready.
- FSM states:
  - ACCUM: in_ready=1, out_valid=0.
  - RESULT: in_ready=0, out_valid=1.
- Registers: cnt (0..N-1), max_val, max_idx, err.
- First beat of frame (cnt==0): unconditionally load max_val=in_data, max_idx=0.
- Later beats: update when in_data > max_val (strict; compare signedness set by SIGNED). max_idx=cnt.
- Ties keep the lowest index.
- cnt increments per accepted beat.
- ACCUM→RESULT on the beat accepted with cnt==N-1. The output regs then hold the final max_val/max_idx.
- err:
  - Set if in_last=1 on any beat with cnt<N-1.
  - Set if in_last=0 on the beat with cnt==N-1.
  - Cleared at frame start.
  - Frame length is always N beats; in_last is advisory only and never shortens or extends a frame.
- RESULT→ACCUM on out_valid && out_ready; cnt=0.
- out_index/out_value/out_err are stable while out_valid=1 and out_ready=0.
- Idle cycles (in_valid=0) inside a frame are allowed; state and registers are held.

## Timing
- Reset (rst_n=0 at a clk edge):
  - state=ACCUM, cnt=0, out_valid=0, out_index=0, out_value=0, out_err=0.
  - in_ready=1 from the first cycle after reset release.
- Reset mid-frame or in RESULT discards the partial frame or pending result. No result beat is emitted for it.
- Latency: out_valid rises the cycle after the N-th beat is accepted.
- in_ready is registered-state-derived only (no combinational path from out_ready).
- Throughput: N+1 cycles per frame when in_valid and out_ready are held high. The RESULT cycle is a one-cycle bubble on the input.
- Backpressure: RESULT persists indefinitely while out_ready=0. in_ready stays 0 during that time, and no beat is dropped.
- in_valid asserted in RESULT is ignored; the producer must hold the beat.

## Structure
- Shared package argmax_pkg:
  - state typedef {ACCUM, RESULT}.
  - Function idx_w(N) returning max(1, $clog2(N)).
  - Signed/unsigned greater-than helper gt(a, b, SIGNED), reused by other reduction blocks.
- One sub-module, argmax_update: the combinational compare-select for one beat.
  - Inputs: cur_val, cur_idx, new_val, new_idx, first.
  - Outputs: next_val, next_idx.
  - The controller owns the FSM, counter, error flag and handshake.

## Test plan
- N=4, WIDTH=16, unsigned. Stream 3, 9, 2, 7 with in_last on the 4th beat, out_ready=1 → one cycle later out_index=1, out_value=9, out_err=0, then in_ready=1.
- Ties: stream 5, 8, 8, 1 → out_index=1, out_value=8.
- Signed (SIGNED=1): stream 0xFFFE, 0xFFF0, 0x8000, 0xFFFF → out_index=3, out_value=0xFFFF. The same vector unsigned gives index 3 as well. Also stream 0x0001, 0xFFFF → signed keeps index 0, unsigned moves to index 1.
- Backpressure: out_ready=0 for 5 cycles after the result → out_valid held with stable fields, in_ready=0, the next frame's first beat is held by the producer. Accepted on the cycle after out_ready=1.
- Framing errors:
  - in_last on beat 2 of 4 → frame still completes after 4 beats with out_err=1.
  - Next frame with in_last only on beat 4 → out_err=0.
- Reset mid-frame after 2 beats (rst_n=0 for 1 cycle) → no result; then a full frame 1, 2, 3, 4 → out_index=3, out_value=4.
